signed_addsub_acc: RTL and testbench
====================================

Name: signed_addsub_acc

Overview:
- Parametrised successor to the 4-bit registered signed adder.
- Per-transaction signed ADD, SUB, ACC (accumulate A) and CLR (clear accumulator) on two's-complement operands.
- Fixed 2-cycle valid pipeline; result width is generic.
- Sits in the datapath as a small arithmetic engine fed by a valid-qualified operand stream.

Parameters:
- WIDTH, 4, operand width in bits (two's complement); legal range 2..32.
- ACC_W, 8, result/accumulator width in bits; must be >= WIDTH+1 (elaboration-time assertion).

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies a, b, op this cycle.
- op  input  2  operation code: ADD=0, SUB=1, ACC=2, CLR=3.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B; ignored for ACC and CLR.
- out_valid  output  1  res and ovf valid this cycle.
- res  output  ACC_W  signed result.
- ovf  output  1  overflow of this result's operation.
- ovf_sticky  output  ACC_W-independent 1  sticky accumulator overflow; cleared by CLR or reset.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all pipeline registers 0, accumulator 0, out_valid=0, res=0, ovf=0, ovf_sticky=0.
- Assertion of reset mid-operation flushes both stages; no out_valid for in-flight transactions.
- Stage 1 (S1): on in_valid=1, register a, b, op and set v1=1. Otherwise v1=0; data registers hold.
- Stage 2 (S2): compute from S1 contents. out_valid=v1 delayed one cycle. Total latency: in_valid at edge N gives out_valid high after edge N+2.
- No backpressure: accepts one transaction per cycle. res, ovf hold their last value when out_valid=0.
- ADD: res = sext(a)+sext(b). Never overflows because ACC_W >= WIDTH+1, so ovf=0.
- SUB: res = sext(a)-sext(b). ovf=0. Example: 7-(-8)=15.
- ACC:
  - acc_next = acc + sext(a), computed at ACC_W+1 bits.
  - If it leaves the ACC_W signed range, ovf=1 and ovf_sticky set; default action is wrap (keep low ACC_W bits).
  - acc updated in S2, so back-to-back ACC transactions chain correctly with no bubble.
  - res = new acc.
- CLR: acc=0, res=0, ovf=0, ovf_sticky=0.
- ADD/SUB do not modify acc or ovf_sticky.
- Op mix: acc is touched only in S2 in transaction order, so interleaving is well defined.

Optional Feature:
- Macro: SIGNED_ADDSUB_ACC_SAT_EN.
- Defined: on ACC overflow, acc and res clamp to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)); ovf and ovf_sticky still assert.
- Undefined: wrap-around as above.
- ADD/SUB unaffected either way.

Decomposition:
- Package addacc_pkg holds:
  - typedef enum logic[1:0] op_e {OP_ADD, OP_SUB, OP_ACC, OP_CLR}
  - default WIDTH/ACC_W constants
  - localparam helpers for ACC_W signed max/min.
- One natural sub-module: sat_clip. Combinational, ACC_W+1 bits in, ACC_W bits out plus ovf; its clamp behaviour is enabled under the macro.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, res=0, ovf=0, ovf_sticky=0. Release reset, keep in_valid=0 -> outputs stay 0.
- ADD corners (WIDTH=4, ACC_W=8):
  - 7+(-8) -> -1
  - 7+7 -> 14
  - -8+-8 -> -16
  - 0+0 -> 0
  - Each appears exactly 2 cycles after issue with ovf=0; back-to-back issue gives one result per cycle.
- SUB: 7-(-8) -> 15; -8-7 -> -15; ovf=0.
- ACC overflow: CLR, then 19 consecutive ACC a=7 -> res 7,14,…,126, then 133 overflows.
  - Wrap build: res=-123, ovf=1, ovf_sticky=1.
  - SAT_EN build: res=127.
  - Following CLR clears res and ovf_sticky.
- Reset mid-op: issue ACC a=5 ×3, assert reset between 2nd and 3rd result -> no further out_valid; acc=0 afterwards. ACC a=1 then returns res=1.
- Mixed stream: CLR, ACC 3, ADD 2+2, ACC -4, SUB 1-1 -> res 0, 3, 4, -1, 0. Acc unaffected by ADD/SUB.

Source files
------------

// File: rtl/addacc_pkg.sv
// Shared types and default sizing for the signed add/sub/accumulate engine.
// Opcode encoding matches the operand stream: ADD=0, SUB=1, ACC=2, CLR=3.
package addacc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ACC_W = 8;

    // Signed range of the default accumulator; sat_clip derives the same limits for any ACC_W.
    localparam int DEF_ACC_MAX = (1 << (DEF_ACC_W - 1)) - 1;
    localparam int DEF_ACC_MIN = -(1 << (DEF_ACC_W - 1));

endpackage

// File: rtl/signed_addsub_acc_sat_clip.sv
// sat_clip: ACC_W+1-bit signed sum narrowed to ACC_W bits; combinational, no backpressure.
// Wraps by default; SIGNED_ADDSUB_ACC_SAT_EN clamps to the signed ACC_W range instead.
module sat_clip
    import addacc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W:0]   sum,
    output logic [ACC_W-1:0] clip,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Range exit shows up as the extra sign bit disagreeing with the ACC_W sign bit.
    assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef SIGNED_ADDSUB_ACC_SAT_EN
    always_comb begin
        clip = sum[ACC_W-1:0];
        if (ovf) begin
            clip = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign clip = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/signed_addsub_acc.sv
// Signed ADD/SUB/ACC/CLR engine on a valid-qualified operand stream (SAT option: SIGNED_ADDSUB_ACC_SAT_EN).
// Latency: fixed 2 cycles from in_valid to out_valid, one transaction per cycle.
// Backpressure: none; res/ovf hold their last value while out_valid is low.
module signed_addsub_acc
    import addacc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [ACC_W-1:0] res,
    output logic             ovf,
    output logic             ovf_sticky
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("signed_addsub_acc: WIDTH must be within 2..32");
        end
        if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
            $error("signed_addsub_acc: ACC_W must be at least WIDTH+1");
        end
    endgenerate

    logic             v1;
    op_e              op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1  <= 1'b0;
            op1 <= OP_ADD;
            a1  <= '0;
            b1  <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                op1 <= op_e'(op);
                a1  <= a;
                b1  <= b;
            end
        end
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] add_r;
    logic [ACC_W-1:0] sub_r;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_clip;
    logic             acc_ovf;

    assign a_ext = {{(ACC_W-WIDTH){a1[WIDTH-1]}}, a1};
    assign b_ext = {{(ACC_W-WIDTH){b1[WIDTH-1]}}, b1};

    // ACC_W >= WIDTH+1 keeps ADD/SUB exact, so only the accumulator path needs range checking.
    assign add_r = a_ext + b_ext;
    assign sub_r = a_ext - b_ext;

    assign acc_sum = {acc[ACC_W-1], acc} + {a_ext[ACC_W-1], a_ext};

    sat_clip #(
        .ACC_W (ACC_W)
    ) u_sat_clip (
        .sum  (acc_sum),
        .clip (acc_clip),
        .ovf  (acc_ovf)
    );

    // acc lives in this stage so back-to-back ACCs see the previous result without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            res        <= '0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
            acc        <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                case (op1)
                    OP_ADD: begin
                        res <= add_r;
                        ovf <= 1'b0;
                    end
                    OP_SUB: begin
                        res <= sub_r;
                        ovf <= 1'b0;
                    end
                    OP_ACC: begin
                        acc        <= acc_clip;
                        res        <= acc_clip;
                        ovf        <= acc_ovf;
                        ovf_sticky <= ovf_sticky | acc_ovf;
                    end
                    OP_CLR: begin
                        acc        <= '0;
                        res        <= '0;
                        ovf        <= 1'b0;
                        ovf_sticky <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_signed_addsub_acc.sv
// Randomised and directed bench for signed_addsub_acc against an integer reference model.
module tb_signed_addsub_acc;

    localparam int WIDTH = 4;
    localparam int ACC_W = 8;
    localparam int LIM   = 1 << (ACC_W - 1);

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             in_valid = 1'b1;
    logic [1:0]       op       = 2'd0;
    logic [WIDTH-1:0] a        = '0;
    logic [WIDTH-1:0] b        = '0;
    logic             out_valid;
    logic [ACC_W-1:0] res;
    logic             ovf;
    logic             ovf_sticky;

    signed_addsub_acc #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .res        (res),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [ACC_W-1:0] res;
        logic             ovf;
        logic             sticky;
    } exp_t;

    exp_t             q[$];
    int               n_cmp     = 0;
    int               n_bad     = 0;
    int               step      = 0;
    int               m_acc     = 0;
    logic             m_sticky  = 1'b0;
    logic [ACC_W-1:0] sh_res    = '0;
    logic             sh_ovf    = 1'b0;
    logic             sh_sticky = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @step %0d: got %0h expected %0h", tag, step, got, exp);
        end
    endtask

    // Reference: results computed in transaction order with plain integer arithmetic.
    task automatic model(input int o, input int av, input int bv);
        exp_t e;
        int   r;
        logic ov;
        ov = 1'b0;
        case (o)
            0: r = av + bv;
            1: r = av - bv;
            2: begin
                r = m_acc + av;
                if (r >= LIM || r < -LIM) begin
                    ov       = 1'b1;
                    m_sticky = 1'b1;
`ifdef SIGNED_ADDSUB_ACC_SAT_EN
                    r = (r >= LIM) ? LIM - 1 : -LIM;
`else
                    r = ((r + LIM + 2 * LIM) % (2 * LIM)) - LIM;
`endif
                end
                m_acc = r;
            end
            default: begin
                r        = 0;
                m_acc    = 0;
                m_sticky = 1'b0;
            end
        endcase
        e.due    = step + 2;
        e.res    = r[ACC_W-1:0];
        e.ovf    = ov;
        e.sticky = m_sticky;
        q.push_back(e);
    endtask

    task automatic observe();
        logic ev;
        ev = (q.size() > 0) && (q[0].due == step);
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            sh_res    = q[0].res;
            sh_ovf    = q[0].ovf;
            sh_sticky = q[0].sticky;
            void'(q.pop_front());
        end
        chk("res", 32'(res), 32'(sh_res));
        chk("ovf", 32'(ovf), 32'(sh_ovf));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(sh_sticky));
    endtask

    task automatic cyc(input bit v, input int o, input int av, input int bv);
        @(negedge clk);
        step++;
        observe();
        reset    = 1'b1;
        in_valid = v;
        op       = 2'(o);
        a        = WIDTH'(av);
        b        = WIDTH'(bv);
        if (v) model(o, av, bv);
    endtask

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step++;
            observe();
            reset     = 1'b0;
            in_valid  = 1'b1;
            q.delete();
            m_acc     = 0;
            m_sticky  = 1'b0;
            sh_res    = '0;
            sh_ovf    = 1'b0;
            sh_sticky = 1'b0;
        end
    endtask

    initial begin
        rst_cycles(2);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(1, 0, 7, -8);
        cyc(1, 0, 7, 7);
        cyc(1, 0, -8, -8);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 7, -8);
        cyc(1, 1, -8, 7);

        cyc(1, 3, 0, 0);
        for (int i = 0; i < 19; i++) cyc(1, 2, 7, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 3, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(1, 3, 0, 0);
        cyc(1, 2, 5, 0);
        cyc(1, 2, 5, 0);
        cyc(1, 2, 5, 0);
        rst_cycles(2);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 2, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(1, 3, 0, 0);
        cyc(1, 2, 3, 0);
        cyc(1, 0, 2, 2);
        cyc(1, 2, -4, 0);
        cyc(1, 1, 1, 1);

        for (int i = 0; i < 600; i++) begin
            int o;
            o = int'($urandom_range(0, 15));
            // Clears kept rare so the accumulator drifts into overflow territory.
            o = (o == 0) ? 3 : (o < 8) ? 2 : (o < 12) ? 0 : 1;
            cyc(($urandom_range(0, 3) != 0), o,
                int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
        end

        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
